// File: rtl/rv_ctrl_pkg.sv
// ============================================================================
// Module : rv_ctrl_pkg
// Brief  : Shared opcodes, state encodings and ALU codes for multicycle_controller.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package rv_ctrl_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEM       = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_HALT      = 3'd5
  } state_e;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  function automatic logic is_known_op(input logic [6:0] op);
    return (op == OP_RTYPE) || (op == OP_LOAD) || (op == OP_STORE) || (op == OP_BRANCH);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_wait_counter.sv
// ============================================================================
// Module : mem_wait_counter
// Brief  : Memory-latency wait counter; 'last' flags the final access cycle.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mem_wait_counter #(
  parameter int MEM_LATENCY = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic last
);

  localparam int            CNT_W    = $clog2(MEM_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Saturates at the terminal count so a missing clear can never wrap it.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != CNT_LAST)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == CNT_LAST);

endmodule

`default_nettype wire

// File: rtl/multicycle_controller.sv
// ============================================================================
// Module : multicycle_controller
// Brief  : RV32 multi-cycle FETCH/DECODE/EXECUTE/MEM/WRITEBACK control FSM.
//          Define MULTICYCLE_ILLEGAL_TRAP_EN to trap unknown opcodes in HALT.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module multicycle_controller #(
  parameter int MEM_LATENCY = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       zero,
  output logic       pc_we,
  output logic       pc_src,
  output logic       ir_we,
  output logic       mem_addr_sel,
  output logic       mem_re,
  output logic       mem_we,
  output logic       reg_file_write,
  output logic [1:0] alu_op,
  output logic       alu_src_b,
  output logic       wb_sel,
  output logic       instr_done,
  output logic [2:0] state
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
  , output logic     illegal_instr
`endif
);

  import rv_ctrl_pkg::*;

  state_e     state_q, state_d;
  logic [6:0] opcode_q, opcode_d;

  logic       w_cnt_en;
  logic       w_cnt_last;
  logic       w_pc_we, w_pc_src, w_ir_we, w_mem_addr_sel, w_mem_re, w_mem_we;
  logic       w_reg_file_write, w_alu_src_b, w_wb_sel, w_instr_done;
  logic [1:0] w_alu_op;

  mem_wait_counter #(
    .MEM_LATENCY (MEM_LATENCY)
  ) u_wait (
    .clock  (clock),
    .reset  (reset),
    .clear  (w_cnt_en & w_cnt_last),
    .enable (w_cnt_en),
    .last   (w_cnt_last)
  );

  always_comb begin
    state_d          = state_q;
    opcode_d         = opcode_q;
    w_cnt_en         = 1'b0;
    w_pc_we          = 1'b0;
    w_pc_src         = 1'b0;
    w_ir_we          = 1'b0;
    w_mem_addr_sel   = 1'b0;
    w_mem_re         = 1'b0;
    w_mem_we         = 1'b0;
    w_reg_file_write = 1'b0;
    w_alu_op         = ALU_ADD;
    w_alu_src_b      = 1'b0;
    w_wb_sel         = 1'b0;
    w_instr_done     = 1'b0;
    case (state_q)
      ST_FETCH: begin
        w_cnt_en = 1'b1;
        w_mem_re = 1'b1;
        if (w_cnt_last) begin
          w_ir_we = 1'b1;
          w_pc_we = 1'b1;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        opcode_d = opcode;
        if (is_known_op(opcode)) begin
          state_d = ST_EXECUTE;
        end else begin
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
          state_d = ST_HALT;
`else
          w_instr_done = 1'b1;
          state_d      = ST_FETCH;
`endif
        end
      end
      ST_EXECUTE: begin
        case (opcode_q)
          OP_RTYPE: begin
            w_alu_op = ALU_FUNCT;
            state_d  = ST_WRITEBACK;
          end
          OP_LOAD, OP_STORE: begin
            w_alu_op    = ALU_ADD;
            w_alu_src_b = 1'b1;
            state_d     = ST_MEM;
          end
          OP_BRANCH: begin
            w_alu_op     = ALU_SUB;
            w_pc_we      = zero;
            w_pc_src     = zero;
            w_instr_done = 1'b1;
            state_d      = ST_FETCH;
          end
          default: state_d = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        w_cnt_en       = 1'b1;
        w_mem_addr_sel = 1'b1;
        w_mem_re       = (opcode_q == OP_LOAD);
        w_mem_we       = (opcode_q == OP_STORE);
        if (w_cnt_last) begin
          if (opcode_q == OP_LOAD) begin
            state_d = ST_WRITEBACK;
          end else begin
            w_instr_done = 1'b1;
            state_d      = ST_FETCH;
          end
        end
      end
      ST_WRITEBACK: begin
        w_reg_file_write = 1'b1;
        w_instr_done     = 1'b1;
        w_wb_sel         = (opcode_q == OP_LOAD);
        state_d          = ST_FETCH;
      end
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
      ST_HALT: state_d = ST_HALT;
`endif
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_FETCH;
      opcode_q <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
    end
  end

  // Reset clears state asynchronously, but FETCH itself drives mem_re, so gate.
  assign pc_we          = w_pc_we          & ~reset;
  assign pc_src         = w_pc_src         & ~reset;
  assign ir_we          = w_ir_we          & ~reset;
  assign mem_addr_sel   = w_mem_addr_sel   & ~reset;
  assign mem_re         = w_mem_re         & ~reset;
  assign mem_we         = w_mem_we         & ~reset;
  assign reg_file_write = w_reg_file_write & ~reset;
  assign alu_op         = w_alu_op         & {2{~reset}};
  assign alu_src_b      = w_alu_src_b      & ~reset;
  assign wb_sel         = w_wb_sel         & ~reset;
  assign instr_done     = w_instr_done     & ~reset;
  assign state          = state_q          & {3{~reset}};
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
  assign illegal_instr  = (state_q == ST_HALT) & ~reset;
`endif

endmodule

`default_nettype wire

// File: tb/tb_multicycle_controller.sv
// ============================================================================
// Module : tb_multicycle_controller
// Brief  : Self-checking bench; three DUTs with MEM_LATENCY 1..3.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_multicycle_controller;

  localparam logic [6:0] R_OP  = 7'b0110011;
  localparam logic [6:0] LD_OP = 7'b0000011;
  localparam logic [6:0] ST_OP = 7'b0100011;
  localparam logic [6:0] BR_OP = 7'b1100011;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef struct packed {
    logic       pc_we;
    logic       pc_src;
    logic       ir_we;
    logic       mem_addr_sel;
    logic       mem_re;
    logic       mem_we;
    logic       reg_file_write;
    logic [1:0] alu_op;
    logic       alu_src_b;
    logic       wb_sel;
    logic       instr_done;
    logic [2:0] state;
  } ctl_t;

  typedef struct {
    int         d;
    logic [6:0] op;
    logic       z;
    int         cycles;
  } vec_t;

  logic       clk = 1'b0;
  logic [2:0] rst_v;
  logic [2:0] zero_v;
  logic [6:0] opc [3];
  ctl_t       obus [3];
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
  logic       ill_a [3];
`endif

  int   tests = 0;
  int   fails = 0;
  ctl_t expq[$];

  always #5 clk = ~clk;

  for (genvar i = 0; i < 3; i++) begin : g_dut
    logic       pc_we, pc_src, ir_we, mem_addr_sel, mem_re, mem_we, rfw, alu_src_b, wb_sel, done;
    logic [1:0] alu_op;
    logic [2:0] st;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    logic       ill;
    assign ill_a[i] = ill;
`endif
    multicycle_controller #(.MEM_LATENCY(i + 1)) u_dut (
      .clock          (clk),
      .reset          (rst_v[i]),
      .opcode         (opc[i]),
      .zero           (zero_v[i]),
      .pc_we          (pc_we),
      .pc_src         (pc_src),
      .ir_we          (ir_we),
      .mem_addr_sel   (mem_addr_sel),
      .mem_re         (mem_re),
      .mem_we         (mem_we),
      .reg_file_write (rfw),
      .alu_op         (alu_op),
      .alu_src_b      (alu_src_b),
      .wb_sel         (wb_sel),
      .instr_done     (done),
      .state          (st)
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
      , .illegal_instr (ill)
`endif
    );
    assign obus[i] = {pc_we, pc_src, ir_we, mem_addr_sel, mem_re, mem_we, rfw,
                      alu_op, alu_src_b, wb_sel, done, st};
  end

  task automatic chk_ctl(input string nm, input ctl_t act, input ctl_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Expected per-cycle control word for one instruction, built segment by segment.
  function automatic void build_expected(input int L, input logic [6:0] op, input logic z);
    ctl_t c;
    bit   ld, st, r, br;
    ld = (op == LD_OP);
    st = (op == ST_OP);
    r  = (op == R_OP);
    br = (op == BR_OP);
    expq.delete();
    for (int k = 0; k < L; k++) begin
      c = '0;
      c.mem_re = 1'b1;
      if (k == L - 1) begin
        c.ir_we = 1'b1;
        c.pc_we = 1'b1;
      end
      expq.push_back(c);
    end
    c = '0;
    c.state = 3'd1;
    if (!(ld || st || r || br)) begin
      c.instr_done = !TRAP;
      expq.push_back(c);
      return;
    end
    expq.push_back(c);
    c = '0;
    c.state = 3'd2;
    if (r) c.alu_op = 2'b10;
    else if (br) c.alu_op = 2'b01;
    else c.alu_src_b = 1'b1;
    if (br) begin
      c.instr_done = 1'b1;
      c.pc_we      = z;
      c.pc_src     = z;
      expq.push_back(c);
      return;
    end
    expq.push_back(c);
    if (ld || st) begin
      for (int k = 0; k < L; k++) begin
        c = '0;
        c.state        = 3'd3;
        c.mem_addr_sel = 1'b1;
        c.mem_re       = ld;
        c.mem_we       = st;
        c.instr_done   = st && (k == L - 1);
        expq.push_back(c);
      end
      if (st) return;
    end
    c = '0;
    c.state          = 3'd4;
    c.reg_file_write = 1'b1;
    c.instr_done     = 1'b1;
    c.wb_sel         = ld;
    expq.push_back(c);
  endfunction

  // Entered and left at a falling edge; junk is driven on inputs outside the cycles that matter.
  task automatic run_instr(input int d, input logic [6:0] op, input logic z,
                           input int stop_after, output int done_at);
    int L;
    int n;
    L = d + 1;
    build_expected(L, op, z);
    done_at = -1;
    n = (stop_after > 0) ? stop_after : expq.size();
    for (int k = 0; k < n; k++) begin
      opc[d]    = (k == L) ? op : 7'($urandom);
      zero_v[d] = (k == L + 1) ? z : 1'($urandom);
      #1;
      chk_ctl($sformatf("L%0d op%b z%0d cyc%0d", L, op, z, k + 1), obus[d], expq[k]);
      if (obus[d].instr_done && done_at < 0) done_at = k + 1;
      @(negedge clk);
    end
  endtask

  task automatic do_reset(input int d);
    rst_v = 3'b111;
    #1;
    chk_ctl($sformatf("reset_L%0d", d + 1), obus[d], '0);
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    chk_int("reset_illegal", int'(ill_a[d]), 0);
`endif
    repeat (2) @(negedge clk);
    rst_v[d] = 1'b0;
  endtask

  function automatic bit known(input logic [6:0] op);
    return op == R_OP || op == LD_OP || op == ST_OP || op == BR_OP;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t       tbl[12];
    int         cur;
    int         da;
    int         d;
    logic [6:0] op;
    ctl_t       hexp;

    tbl[0]  = '{0, R_OP,    1'b0, 4};
    tbl[1]  = '{2, LD_OP,   1'b0, 9};
    tbl[2]  = '{0, BR_OP,   1'b1, 3};
    tbl[3]  = '{0, BR_OP,   1'b0, 3};
    tbl[4]  = '{1, ST_OP,   1'b0, 6};
    tbl[5]  = '{1, R_OP,    1'b1, 5};
    tbl[6]  = '{2, ST_OP,   1'b0, 8};
    tbl[7]  = '{2, BR_OP,   1'b1, 5};
    tbl[8]  = '{0, 7'h7F,   1'b0, 2};
    tbl[9]  = '{2, 7'h7F,   1'b0, 4};
    tbl[10] = '{1, LD_OP,   1'b0, 7};
    tbl[11] = '{0, LD_OP,   1'b0, 5};

    rst_v  = 3'b111;
    zero_v = 3'b000;
    for (int i = 0; i < 3; i++) opc[i] = 7'd0;
    @(negedge clk);

    cur = -1;
    foreach (tbl[t]) begin
      if (TRAP && !known(tbl[t].op)) continue;
      if (tbl[t].d != cur) begin
        do_reset(tbl[t].d);
        cur = tbl[t].d;
      end
      run_instr(tbl[t].d, tbl[t].op, tbl[t].z, 0, da);
      chk_int($sformatf("len_t%0d", t), da, tbl[t].cycles);
      chk_int($sformatf("refetch_t%0d", t),
              int'({obus[tbl[t].d].state, obus[tbl[t].d].mem_re}), 1);
    end

    // Reset in the second MEM cycle of a load at latency 3.
    do_reset(2);
    run_instr(2, LD_OP, 1'b0, 6, da);
    #1;
    chk_ctl("pre_reset_mem2", obus[2], expq[6]);
    rst_v[2] = 1'b1;
    #1;
    chk_ctl("mid_reset_zero", obus[2], '0);
    @(negedge clk);
    @(negedge clk);
    rst_v[2] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk_int($sformatf("post_reset_c%0d", k + 1),
              int'({obus[2].state, obus[2].mem_re, obus[2].ir_we}), 2 | int'(k == 2));
      @(negedge clk);
    end
    opc[2] = R_OP;
    #1;
    chk_int("post_reset_decode", int'({obus[2].state, obus[2].mem_re}), 2);
    @(negedge clk);
    cur = -1;

`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    do_reset(0);
    run_instr(0, 7'h7F, 1'b0, 0, da);
    hexp = '0;
    hexp.state = 3'd5;
    for (int k = 0; k < 20; k++) begin
      opc[0]    = 7'($urandom);
      zero_v[0] = 1'($urandom);
      #1;
      chk_ctl($sformatf("halt_c%0d", k), obus[0], hexp);
      chk_int($sformatf("halt_ill_c%0d", k), int'(ill_a[0]), 1);
      @(negedge clk);
    end
`else
    // Opcode changes around DECODE must not matter: NOP then R back to back.
    do_reset(1);
    run_instr(1, 7'h00, 1'b0, 0, da);
    chk_int("nop_len", da, 3);
    run_instr(1, R_OP, 1'b0, 0, da);
    chk_int("r_after_nop_len", da, 5);
    hexp = '0;
`endif

    repeat (60) begin
      d = $urandom_range(0, 2);
      do_reset(d);
      repeat ($urandom_range(1, 4)) begin
        case ($urandom_range(0, 4))
          0: op = R_OP;
          1: op = LD_OP;
          2: op = ST_OP;
          3: op = BR_OP;
          default: op = 7'($urandom);
        endcase
        if (TRAP && !known(op)) op = R_OP;
        run_instr(d, op, 1'($urandom), 0, da);
        chk_int($sformatf("rand_len L%0d op%b", d + 1, op), da, expq.size());
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multi-cycle FSM that sequences the RV32 datapath through FETCH/DECODE/EXECUTE/MEM/WRITEBACK, one instruction at a time.
- Supports R-type (0110011), load (0000011), store (0100011) and branch (1100011) instructions.
- Replaces the per-cycle opcode decoder as the datapath's control source.
- Stalls in FETCH and MEM for a fixed memory latency, using an internal wait counter.

Parameters:
- MEM_LATENCY, 1: cycles per instruction/data memory access; legal range >= 1.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high; clears state and counter, forces all outputs to 0 while high.
- opcode  in  7  instr[6:0] from the instruction register; sampled only in DECODE.
- zero  in  1  ALU zero flag; sampled only in EXECUTE of a branch.
- pc_we  out  1  PC register write enable.
- pc_src  out  1  0 = PC+4, 1 = branch target (old_pc+imm).
- ir_we  out  1  instruction register write enable.
- mem_addr_sel  out  1  0 = PC, 1 = ALU result.
- mem_re  out  1  memory read.
- mem_we  out  1  memory write.
- reg_file_write  out  1  register file write enable.
- alu_op  out  2  00 add, 01 sub/compare, 10 funct-decoded.
- alu_src_b  out  1  0 = rs2, 1 = immediate.
- wb_sel  out  1  0 = ALU result, 1 = memory data.
- instr_done  out  1  one-cycle pulse on the last cycle of every instruction.
- state  out  3  current state encoding, for debug.

Behaviour:
- State encodings: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WRITEBACK=4, HALT=5 (HALT exists only with the macro). 6 and 7 are unused and recover to FETCH.
- State register, wait counter (width $clog2(MEM_LATENCY+1)) and opcode_q use async reset to FETCH / 0 / 0.
- Outputs are combinational from state, opcode_q, zero and the counter, ANDed with ~reset. Every output is 0 during reset.
- FETCH:
  - mem_re=1 and mem_addr_sel=0 on every cycle.
  - Counter increments until it reaches MEM_LATENCY-1.
  - On that last cycle: ir_we=1, pc_we=1, pc_src=0; counter clears; next state is DECODE.
- DECODE:
  - opcode_q <= opcode.
  - Known opcode -> EXECUTE.
  - Unknown opcode: see Optional Feature.
- EXECUTE:
  - R: alu_op=10, alu_src_b=0 -> WRITEBACK.
  - Load/store: alu_op=00, alu_src_b=1 -> MEM.
  - Branch: alu_op=01, alu_src_b=0. If zero=1 then pc_we=1 and pc_src=1. Asserts instr_done -> FETCH.
- MEM:
  - mem_addr_sel=1 throughout.
  - Load: mem_re=1. Store: mem_we=1. Asserted on every MEM cycle.
  - Counter runs as in FETCH.
  - On the last cycle: load -> WRITEBACK; store asserts instr_done -> FETCH.
- WRITEBACK:
  - reg_file_write=1 and instr_done=1.
  - wb_sel=1 for load, 0 for R -> FETCH.
- Cycles per instruction (L = MEM_LATENCY):
  - R: L+3.
  - Load: 2L+3.
  - Store: 2L+2.
  - Branch: L+2.
- The counter is 0 on entry to FETCH and MEM. It never wraps past MEM_LATENCY-1.
- When MEM_LATENCY=1, FETCH and MEM are single-cycle.
- A change on opcode outside DECODE has no effect.
- Reset asserted in any state (including mid-wait): outputs drop to 0 immediately. After release, the first cycle is FETCH with counter=0.

Optional Feature:
- Macro: MULTICYCLE_ILLEGAL_TRAP_EN.
- Defined:
  - Unknown opcode in DECODE -> HALT.
  - HALT drives all outputs 0 and never exits except by reset.
  - Adds output illegal_instr (1 bit), which is high in HALT and 0 otherwise.
- Undefined:
  - Unknown opcode in DECODE asserts instr_done for one cycle and returns to FETCH (NOP).
  - No HALT state and no illegal_instr port.

Decomposition:
- Package rv_ctrl_pkg holds:
  - Opcode localparams: OP_RTYPE, OP_LOAD, OP_STORE, OP_BRANCH.
  - State encodings: ST_FETCH..ST_HALT.
  - ALU op codes: ALU_ADD=00, ALU_SUB=01, ALU_FUNCT=10.
- Sub-module mem_wait_counter (parameter MEM_LATENCY).
  - Inputs: clear, enable. Output: last.
  - Instantiated once; shared by FETCH and MEM.

Test Plan:
- MEM_LATENCY=1, opcode=0110011: states 0,1,2,4.
  - alu_op=10 in cycle 3.
  - reg_file_write=1, wb_sel=0 and instr_done in cycle 4 only.
  - Back to FETCH in cycle 5.
- MEM_LATENCY=3, opcode=0000011:
  - mem_re high in cycles 1-3 (addr_sel=0); ir_we and pc_we in cycle 3 only.
  - MEM in cycles 6-8 with mem_re=1, addr_sel=1.
  - WRITEBACK in cycle 9 with wb_sel=1 and reg_file_write=1. Total 9 cycles.
- MEM_LATENCY=1, opcode=1100011:
  - zero=1 -> pc_we=1, pc_src=1, instr_done in cycle 3.
  - zero=0 -> pc_we=0 in cycle 3.
  - Both cases return to FETCH in cycle 4.
- MEM_LATENCY=2, opcode=0100011:
  - mem_we=1 in cycles 5-6; instr_done in cycle 6.
  - reg_file_write stays 0 throughout; next FETCH in cycle 7.
- MEM_LATENCY=3, load: assert reset during the 2nd MEM cycle.
  - All outputs go 0 the same cycle.
  - After release: state=0, and mem_re is high for exactly 3 cycles before ir_we.
- opcode=1111111:
  - Macro undefined: instr_done in DECODE, then FETCH.
  - Macro defined: state=5, illegal_instr=1, all other outputs 0 for 20 cycles until reset.
